// File: rtl/positmult_prod_4_raw_es3_if.sv
// Operand/result bundle for the raw es=3 posit multiplier.
//   start     : operation valid (one op per cycle, no backpressure)
//   in1, in2  : unpacked operands {sgn, scale[8:0], frac[FBITS-1:0], inf, zero}
//   result    : {sgn, scale[9:0], frac[2*FBITS-1:0], inf, zero}
//   done      : result valid
//   truncated : a nonzero product bit was dropped while normalizing
// master drives operands, slave (the multiplier) drives results.
interface positmult_prod_4_raw_es3_if #(
  parameter int FBITS = 27
);
  logic                   start;
  logic [FBITS+11:0]      in1;
  logic [FBITS+11:0]      in2;
  logic [2*FBITS+12:0]    result;
  logic                   done;
  logic                   truncated;

  modport master (output start, in1, in2, input result, done, truncated);
  modport slave  (input start, in1, in2, output result, done, truncated);
endinterface

// File: rtl/positmult_prod_4_raw_es3.sv
// Pipelined raw posit (es=3) multiplier feeding the 8-stage product adder.
// Fully pipelined, one op per cycle, start/done tagged, fixed latency:
// start sampled at edge n gives done with its result after edge n+4.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, drops all in-flight ops
//   bus  : slave side of positmult_prod_4_raw_es3_if (start/in1/in2 in,
//          result/done/truncated out)
module positmult_prod_4_raw_es3 #(
  parameter int FBITS = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  positmult_prod_4_raw_es3_if.slave     bus
);
  localparam int LATENCY = 4;
  localparam int MW      = FBITS + 1;   // mantissa with hidden bit
  localparam int LW      = MW / 2;      // low split of mB
  localparam int HW      = MW - LW;     // high split of mB
  localparam int PW      = 2 * MW;      // full product width

  typedef struct packed {
    logic             sgn;
    logic [8:0]       scale;
    logic [FBITS-1:0] frac;
    logic             inf;
    logic             zero;
  } posit_in_t;

  typedef struct packed {
    logic       sgn;
    logic [9:0] scale;
    logic       inf;
    logic       zero;
  } meta_t;

  // A zero operand carries no meaningful fields; flatten it so stale
  // sign/scale/fraction bits can never leak into the product.
  function automatic posit_in_t canon(input posit_in_t p);
    posit_in_t c;
    c = p;
    if (p.zero) begin
      c      = '0;
      c.zero = 1'b1;
    end
    return c;
  endfunction

  logic [LATENCY:0] vld_pipe;
  logic             start_v;

  posit_in_t             a0, b0;
  meta_t                 m1, m2, m3;
  logic [MW-1:0]         ma1, mb1;
  logic [MW+LW-1:0]      pp_lo2;
  logic [MW+HW-1:0]      pp_hi2;
  logic [PW-1:0]         p3;
  logic [2*FBITS+12:0]   result_q;
  logic                  trunc_q;

  // An X on start must not launch an op: an X condition takes the default.
  always_comb begin
    start_v = 1'b0;
    if (bus.start) start_v = 1'b1;
  end

  // Special-case resolution for stage 1.
  logic a_inf_or, a_zero_or;
  assign a_inf_or  = a0.inf | b0.inf;
  assign a_zero_or = (a0.zero | b0.zero) & ~a_inf_or;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a0       <= '0;
      b0       <= '0;
      m1       <= '0;
      m2       <= '0;
      m3       <= '0;
      ma1      <= '0;
      mb1      <= '0;
      pp_lo2   <= '0;
      pp_hi2   <= '0;
      p3       <= '0;
      result_q <= '0;
      trunc_q  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:0], start_v};

      // Stage 0: capture operands.
      a0 <= canon(posit_in_t'(bus.in1));
      b0 <= canon(posit_in_t'(bus.in2));

      // Stage 1: sign, scale sum, flags, mantissas.
      m1.inf  <= a_inf_or;
      m1.zero <= a_zero_or;
      if (a_inf_or | a_zero_or) begin
        m1.sgn   <= 1'b0;
        m1.scale <= '0;
      end else begin
        m1.sgn   <= a0.sgn ^ b0.sgn;
        m1.scale <= {a0.scale[8], a0.scale} + {b0.scale[8], b0.scale};
      end
      ma1 <= {1'b1, a0.frac};
      mb1 <= {1'b1, b0.frac};

      // Stage 2: partial products split on the low half of mB.
      m2     <= m1;
      pp_lo2 <= ma1 * mb1[LW-1:0];
      pp_hi2 <= ma1 * mb1[MW-1:LW];

      // Stage 3: full product, in [1,4) with two integer bits.
      m3 <= m2;
      p3 <= PW'(pp_lo2) + (PW'(pp_hi2) << LW);

      // Stage 4: normalize to one integer bit. Scale cannot overflow
      // 10 signed bits (max 255+255+1), so no saturation.
      if (m3.inf | m3.zero) begin
        result_q <= {65'b0, m3.inf, m3.zero};
        trunc_q  <= 1'b0;
      end else if (p3[PW-1]) begin
        result_q <= {m3.sgn, m3.scale + 10'd1, p3[PW-2:1], 2'b00};
        trunc_q  <= p3[0];
      end else begin
        result_q <= {m3.sgn, m3.scale, p3[PW-3:0], 2'b00};
        trunc_q  <= 1'b0;
      end
    end
  end

  assign bus.done      = vld_pipe[LATENCY];
  assign bus.result    = result_q;
  assign bus.truncated = trunc_q;
endmodule

// File: tb/tb_positmult_prod_4_raw_es3.sv
module tb_positmult_prod_4_raw_es3;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  positmult_prod_4_raw_es3_if #(.FBITS(27)) bus ();
  positmult_prod_4_raw_es3 #(.FBITS(27)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [38:0] mk(input logic s, input logic [8:0] sc,
                                     input logic [26:0] f, input logic inf,
                                     input logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [66:0] mkr(input logic s, input logic [9:0] sc,
                                      input logic [53:0] f, input logic inf,
                                      input logic z);
    return {s, sc, f, inf, z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for done; lat = edges after the sampling edge.
  task automatic issue(input logic [38:0] a, input logic [38:0] b,
                       output logic [66:0] r, output logic tr, output int lat);
    bus.start = 1'b1; bus.in1 = a; bus.in2 = b;
    tick();
    bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
    lat = -1;
    r = '0; tr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) begin
        lat = i; r = bus.result; tr = bus.truncated;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
    repeat (3) tick();
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 67'd0 || bus.truncated !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: done=%b result=%h trunc=%b, want 0/0/0",
               bus.done, bus.result, bus.truncated);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_latency();
    logic [66:0] r; logic tr; int lat;
    issue(mk(0, 9'd0, 27'd0, 0, 0), mk(0, 9'd0, 27'd0, 0, 0), r, tr, lat);
    checks++;
    if (lat !== 4) begin
      fails++; $display("FAIL latency_1x1: got %0d, want 4", lat);
    end
    checks++;
    if (r !== 67'd0 || tr !== 1'b0) begin
      fails++; $display("FAIL result_1x1: got %h/%b, want 0/0", r, tr);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      fails++; $display("FAIL done_single_pulse: got %b, want 0", bus.done);
    end
  endtask

  task automatic test_norm_carry();
    logic [66:0] r; logic tr; int lat;
    logic [66:0] exp;
    exp = mkr(0, 10'd1, {3'b001, 51'd0}, 0, 0);
    issue(mk(0, 9'd0, 27'h4000000, 0, 0), mk(0, 9'd0, 27'h4000000, 0, 0), r, tr, lat);
    checks++;
    if (lat !== 4 || r !== exp || tr !== 1'b0) begin
      fails++;
      $display("FAIL norm_1p5sq: lat=%0d r=%h tr=%b, want 4 %h 0", lat, r, tr, exp);
    end
  endtask

  task automatic test_sign_negscale();
    logic [66:0] r; logic tr; int lat;
    logic [66:0] exp;
    exp = mkr(1, 10'd0, 54'd0, 0, 0);
    issue(mk(1, 9'd1, 27'd0, 0, 0), mk(0, 9'h1FF, 27'd0, 0, 0), r, tr, lat);
    checks++;
    if (lat !== 4 || r !== exp || tr !== 1'b0) begin
      fails++;
      $display("FAIL sign_negscale: lat=%0d r=%h tr=%b, want 4 %h 0", lat, r, tr, exp);
    end
  endtask

  task automatic test_special();
    logic [66:0] r; logic tr; int lat;
    issue(mk(0, 9'd0, 27'd0, 0, 1), mk(0, 9'd0, 27'd0, 1, 0), r, tr, lat);
    checks++;
    if (lat !== 4 || r !== 67'b10 || tr !== 1'b0) begin
      fails++;
      $display("FAIL zero_x_inf: lat=%0d r=%h tr=%b, want 4 2 0", lat, r, tr);
    end
    issue(mk(1, 9'd7, 27'h55, 0, 1), mk(0, 9'd5, 27'h1234, 0, 0), r, tr, lat);
    checks++;
    if (lat !== 4 || r !== 67'b01 || tr !== 1'b0) begin
      fails++;
      $display("FAIL zero_x_val: lat=%0d r=%h tr=%b, want 4 1 0", lat, r, tr);
    end
  endtask

  task automatic test_max();
    logic [66:0] r; logic tr; int lat;
    logic [66:0] exp;
    // (2^28-1)^2 = 2^56 - 2^29 + 1: P[55:29] ones, P[0] one.
    exp = mkr(0, 10'd511, {{26{1'b1}}, 28'd0}, 0, 0);
    issue(mk(0, 9'd255, {27{1'b1}}, 0, 0), mk(0, 9'd255, {27{1'b1}}, 0, 0), r, tr, lat);
    checks++;
    if (lat !== 4 || r !== exp) begin
      fails++; $display("FAIL max_result: lat=%0d r=%h, want 4 %h", lat, r, exp);
    end
    checks++;
    if (tr !== 1'b1) begin
      fails++; $display("FAIL max_truncated: got %b, want 1", tr);
    end
  endtask

  task automatic test_back_to_back();
    logic [38:0] a [4];
    logic [38:0] b [4];
    logic [66:0] e [4];
    logic        et [4];
    int k;
    a[0] = mk(0, 9'd0, 27'd0, 0, 0);       b[0] = a[0];
    e[0] = mkr(0, 10'd0, 54'd0, 0, 0);     et[0] = 0;
    a[1] = mk(0, 9'd0, 27'h4000000, 0, 0); b[1] = a[1];
    e[1] = mkr(0, 10'd1, {3'b001, 51'd0}, 0, 0); et[1] = 0;
    a[2] = mk(1, 9'd1, 27'd0, 0, 0);       b[2] = mk(0, 9'h1FF, 27'd0, 0, 0);
    e[2] = mkr(1, 10'd0, 54'd0, 0, 0);     et[2] = 0;
    a[3] = mk(0, 9'd255, {27{1'b1}}, 0, 0); b[3] = a[3];
    e[3] = mkr(0, 10'd511, {{26{1'b1}}, 28'd0}, 0, 0); et[3] = 1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        bus.start = 1'b1; bus.in1 = a[i]; bus.in2 = b[i];
      end else begin
        bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
      end
      tick();
      if (bus.done === 1'b1) begin
        checks++;
        if (k > 3 || i !== 4 + k || bus.result !== e[k] || bus.truncated !== et[k]) begin
          fails++;
          $display("FAIL stream_%0d: at tick %0d r=%h tr=%b", k, i, bus.result, bus.truncated);
        end
        k++;
      end
    end
    checks++;
    if (k !== 4) begin
      fails++; $display("FAIL stream_count: got %0d dones, want 4", k);
    end
  endtask

  task automatic test_reset_midflight();
    logic [66:0] r; logic tr; int lat;
    int dones;
    bus.in1 = mk(0, 9'd3, 27'h123, 0, 0); bus.in2 = mk(1, 9'd2, 27'h456, 0, 0);
    bus.start = 1'b1;
    tick();
    tick();
    rst = 1'b1;   // third start sampled together with rst
    tick();
    rst = 1'b0; bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 67'd0 || bus.truncated !== 1'b0) begin
      fails++;
      $display("FAIL rst_clear: done=%b result=%h trunc=%b, want 0/0/0",
               bus.done, bus.result, bus.truncated);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      fails++; $display("FAIL rst_drop: got %0d dones, want 0", dones);
    end
    // X on start must not launch an op.
    bus.start = 1'bx;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      fails++; $display("FAIL x_start: got %0d dones, want 0", dones);
    end
    issue(mk(1, 9'd1, 27'd0, 0, 0), mk(0, 9'h1FF, 27'd0, 0, 0), r, tr, lat);
    checks++;
    if (lat !== 4 || r !== mkr(1, 10'd0, 54'd0, 0, 0)) begin
      fails++; $display("FAIL post_rst_op: lat=%0d r=%h, want 4", lat, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_norm_carry();
    test_sign_negscale();
    test_special();
    test_max();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
